// File: rtl/mm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mm_pkg: shared types and operand-packing helpers for mm3       |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package mm_pkg;

  localparam int MM_ELEM_W = 16;
  localparam int N         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Element (r,c) of a row-major packed 3x3 matrix.
  function automatic logic [MM_ELEM_W-1:0] elem(input logic [N*N*MM_ELEM_W-1:0] mat,
                                                input logic [1:0] r,
                                                input logic [1:0] c);
    return mat[MM_ELEM_W*(N*r + c) +: MM_ELEM_W];
  endfunction

  function automatic logic [N*MM_ELEM_W-1:0] row(input logic [N*N*MM_ELEM_W-1:0] mat,
                                                 input logic [1:0] r);
    logic [N*MM_ELEM_W-1:0] v;
    for (int k = 0; k < N; k++) v[MM_ELEM_W*k +: MM_ELEM_W] = elem(mat, r, 2'(k));
    return v;
  endfunction

  function automatic logic [N*MM_ELEM_W-1:0] col(input logic [N*N*MM_ELEM_W-1:0] mat,
                                                 input logic [1:0] c);
    logic [N*MM_ELEM_W-1:0] v;
    for (int k = 0; k < N; k++) v[MM_ELEM_W*k +: MM_ELEM_W] = elem(mat, 2'(k), c);
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm3_operand_mux.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mm3_operand_mux: selects A row idx/3 and B column idx%3         |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module mm3_operand_mux
  import mm_pkg::*;
#(
  parameter int ELEM_W = MM_ELEM_W
) (
  input  logic [N*N*ELEM_W-1:0] a_i,
  input  logic [N*N*ELEM_W-1:0] b_i,
  input  logic [3:0]            idx_i,
  output logic [N*ELEM_W-1:0]   row_o,
  output logic [N*ELEM_W-1:0]   col_o
);

  logic [1:0] r_sel;
  logic [1:0] c_sel;

  always_comb begin
    r_sel = 2'd0;
    c_sel = 2'd0;
    case (idx_i)
      4'd1:    c_sel = 2'd1;
      4'd2:    c_sel = 2'd2;
      4'd3:    r_sel = 2'd1;
      4'd4:    begin r_sel = 2'd1; c_sel = 2'd1; end
      4'd5:    begin r_sel = 2'd1; c_sel = 2'd2; end
      4'd6:    r_sel = 2'd2;
      4'd7:    begin r_sel = 2'd2; c_sel = 2'd1; end
      4'd8:    begin r_sel = 2'd2; c_sel = 2'd2; end
      default: begin r_sel = 2'd0; c_sel = 2'd0; end
    endcase
  end

  if (ELEM_W == MM_ELEM_W) begin : g_pkg
    assign row_o = row(a_i, r_sel);
    assign col_o = col(b_i, c_sel);
  end else begin : g_generic
    always_comb begin
      for (int k = 0; k < N; k++) begin
        row_o[ELEM_W*k +: ELEM_W] = a_i[ELEM_W*(N*r_sel + k) +: ELEM_W];
        col_o[ELEM_W*k +: ELEM_W] = b_i[ELEM_W*(N*k + c_sel) +: ELEM_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mm3_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mm3_sequencer: time-shares one 3-term dot unit for C = A x B    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module mm3_sequencer
  import mm_pkg::*;
#(
  parameter int ELEM_W = MM_ELEM_W,
  parameter int DP_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [N*N*ELEM_W-1:0] a_i,
  input  logic [N*N*ELEM_W-1:0] b_i,
  output logic [N*ELEM_W-1:0]   dp_row_o,
  output logic [N*ELEM_W-1:0]   dp_col_o,
  output logic                  dp_vld_o,
  input  logic [ELEM_W-1:0]     dp_res_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N*N*ELEM_W-1:0] c_o
);

  state_e                state_q, state_d;
  logic [N*N*ELEM_W-1:0] a_snap_q, a_snap_d;
  logic [N*N*ELEM_W-1:0] b_snap_q, b_snap_d;
  logic [N*N*ELEM_W-1:0] bank_q, bank_d;
  logic [N*N*ELEM_W-1:0] c_q, c_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [N*ELEM_W-1:0]   row_q, row_d;
  logic [N*ELEM_W-1:0]   col_q, col_d;
  logic                  vld_q, vld_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  issue;
  logic [N*ELEM_W-1:0]   mux_row;
  logic [N*ELEM_W-1:0]   mux_col;

  // The mux looks at next-state snapshot/index so operands are registered
  // on the very edge that enters ISSUE, making dp_vld_o coincide with ISSUE.
  mm3_operand_mux #(
    .ELEM_W (ELEM_W)
  ) u_mux (
    .a_i   (a_snap_d),
    .b_i   (b_snap_d),
    .idx_i (idx_d),
    .row_o (mux_row),
    .col_o (mux_col)
  );

  always_comb begin
    state_d  = state_q;
    a_snap_d = a_snap_q;
    b_snap_d = b_snap_q;
    bank_d   = bank_q;
    c_d      = c_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_snap_d = a_i;
          b_snap_d = b_i;
          idx_d    = 4'd0;
          busy_d   = 1'b1;
          issue    = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = 4'(DP_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          bank_d[ELEM_W*idx_q +: ELEM_W] = dp_res_i;
          if (idx_q == 4'd8) begin
            // Last result goes straight into c_o alongside the done pulse.
            c_d     = bank_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            issue   = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        idx_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    vld_d = 1'b0;
    if (issue) begin
      row_d = mux_row;
      col_d = mux_col;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_snap_q <= '0;
      b_snap_q <= '0;
      bank_q   <= '0;
      c_q      <= '0;
      idx_q    <= 4'd0;
      wcnt_q   <= 4'd0;
      row_q    <= '0;
      col_q    <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_snap_q <= a_snap_d;
      b_snap_q <= b_snap_d;
      bank_q   <= bank_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dp_row_o = row_q;
  assign dp_col_o = col_q;
  assign dp_vld_o = vld_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign c_o      = c_q;

endmodule
`default_nettype wire

// File: tb/tb_mm3_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_mm3_sequencer: directed bench, DP_LAT=1 and DP_LAT=3 DUTs    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_mm3_sequencer;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start1 = 1'b0;
  logic          start3 = 1'b0;
  logic [143:0]  a = '0;
  logic [143:0]  b = '0;

  logic [47:0]   row1, col1, row3, col3;
  logic          vld1, vld3, busy1, busy3, done1, done3;
  logic [15:0]   res1;
  logic [15:0]   p3 [3];
  logic [143:0]  c1, c3;

  always #5 clk = ~clk;

  mm3_sequencer #(.ELEM_W(16), .DP_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .a_i(a), .b_i(b),
    .dp_row_o(row1), .dp_col_o(col1), .dp_vld_o(vld1), .dp_res_i(res1),
    .busy_o(busy1), .done_o(done1), .c_o(c1)
  );

  mm3_sequencer #(.ELEM_W(16), .DP_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start3), .a_i(a), .b_i(b),
    .dp_row_o(row3), .dp_col_o(col3), .dp_vld_o(vld3), .dp_res_i(p3[2]),
    .busy_o(busy3), .done_o(done3), .c_o(c3)
  );

  // External dot unit: truncated 3-term dot product, garbage when not valid
  function automatic logic [15:0] dot3(input logic [47:0] r, input logic [47:0] c);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < 3; k++) s = s + r[16*k +: 16] * c[16*k +: 16];
    return s[15:0];
  endfunction

  always @(posedge clk) begin
    res1  <= vld1 ? dot3(row1, col1) : 16'hBEEF;
    p3[0] <= vld3 ? dot3(row3, col3) : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  int           done_cyc, vld_cnt, vld_bad, busy_bad, c_chg, busy_done;
  logic [143:0] c_done;
  logic [47:0]  row_at1, col_at1, col_at2;

  // Starts one run on the selected DUT and observes it cycle by cycle.
  // Cycle 1 is the cycle after the edge that accepts start.
  task automatic run(input int lat, input logic [143:0] av, input logic [143:0] bv,
                     input bit disturb);
    logic [143:0] c_prev;
    logic         dn, vl, bs;
    logic [143:0] cv;
    a = av;
    b = bv;
    @(negedge clk);
    if (lat == 1) start1 = 1'b1; else start3 = 1'b1;
    c_prev = (lat == 1) ? c1 : c3;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
    done_cyc = -1; vld_cnt = 0; vld_bad = 0; busy_bad = 0; c_chg = 0; busy_done = -1;
    c_done = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      dn = (lat == 1) ? done1 : done3;
      vl = (lat == 1) ? vld1  : vld3;
      bs = (lat == 1) ? busy1 : busy3;
      cv = (lat == 1) ? c1    : c3;
      if (cyc == 1) begin
        row_at1 = (lat == 1) ? row1 : row3;
        col_at1 = (lat == 1) ? col1 : col3;
      end
      if (cyc == 2) col_at2 = (lat == 1) ? col1 : col3;
      if (disturb) begin
        if (cyc == 3) a = {9{16'h0002}};
        start1 = (cyc == 5 || cyc == 19);
      end
      if (dn) begin
        done_cyc  = cyc;
        c_done    = cv;
        busy_done = int'(bs);
        break;
      end
      if (vl) vld_cnt++;
      if (vl != ((cyc % (lat + 1)) == 1)) vld_bad++;
      if (!bs) busy_bad++;
      if (cv != c_prev) c_chg++;
    end
  endtask

  logic [143:0] a_id, b_seq, a_w, b_w;
  int           n_done, n_busy;

  initial begin
    for (int k = 0; k < 9; k++) begin
      a_id[16*k +: 16]  = (k % 4 == 0) ? 16'd1 : 16'd0;
      b_seq[16*k +: 16] = 16'(k + 1);
      b_w[16*k +: 16]   = (k % 3 == 0) ? 16'd2 : 16'd0;
    end
    a_w = '0;
    a_w[47:0] = {3{16'h8000}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out1", {row1, col1, vld1, busy1, done1, c1}, '0);
    chk("reset_out3", {row3, col3, vld3, busy3, done3, c3}, '0);
    rst_n = 1'b1;

    // Identity x 1..9
    run(1, a_id, b_seq, 1'b0);
    chk("t1_done_cyc", done_cyc, 19);
    chk("t1_c", c_done, b_seq);
    chk("t1_busy_1_18", busy_bad, 0);
    chk("t1_busy_at_done", busy_done, 0);
    chk("t1_c_hold", c_chg, 0);
    chk("t1_row0", row_at1, 48'h0000_0000_0001);
    chk("t1_col0", col_at1, {16'd7, 16'd4, 16'd1});
    chk("t1_col_hold", col_at2, {16'd7, 16'd4, 16'd1});

    // All 2 x all 3
    run(1, {9{16'h0002}}, {9{16'h0003}}, 1'b0);
    chk("t2_c", c_done, {9{16'h0012}});
    chk("t2_vld_cnt", vld_cnt, 9);
    chk("t2_vld_pos", vld_bad, 0);
    chk("t2_done_cyc", done_cyc, 19);

    // Wrap modulo 2^16
    run(1, a_w, b_w, 1'b0);
    chk("t3_c", c_done, 144'd0);
    chk("t3_done_cyc", done_cyc, 19);

    // Ignored restarts and a_i change after acceptance
    run(1, a_id, b_seq, 1'b1);
    chk("t4_c", c_done, b_seq);
    chk("t4_done_cyc", done_cyc, 19);
    @(negedge clk);
    start1 = 1'b0;
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1) n_done++;
      if (busy1) n_busy++;
    end
    chk("t4_extra_done", n_done, 0);
    chk("t4_extra_busy", n_busy, 0);

    // Reset mid-run
    a = a_id;
    b = b_seq;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) @(negedge clk);
    chk("t5_busy_pre", busy1, 1'b1);
    chk("t5_c_pre", c1, b_seq);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out", {row1, col1, vld1, busy1, done1, c1}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done1) n_done++;
    end
    chk("t5_no_done", n_done, 0);
    chk("t5_c_zero", c1, 144'd0);
    run(1, {9{16'h0002}}, {9{16'h0003}}, 1'b0);
    chk("t5_rerun_c", c_done, {9{16'h0012}});
    chk("t5_rerun_cyc", done_cyc, 19);

    // DP_LAT = 3
    run(3, {9{16'h0002}}, {9{16'h0003}}, 1'b0);
    chk("t6_done_cyc", done_cyc, 37);
    chk("t6_c", c_done, {9{16'h0012}});
    chk("t6_vld_cnt", vld_cnt, 9);
    chk("t6_vld_pos", vld_bad, 0);
    chk("t6_busy", busy_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mm3_sequencer.md
Name: mm3_sequencer

Overview:
Controller that time-shares one 3-term dot-product unit (16-bit elements) to compute a full 3x3 matrix product C = A x B, one output element at a time.
- Replaces nine parallel dot-product instances with one shared unit plus this sequencer.
- Snapshots both operand matrices on start, issues row/column operand pairs in row-major order, captures each result and publishes the completed C matrix with a done pulse.

Parameters:
ELEM_W, 16, element width in bits.
DP_LAT, 1, cycles from dp_vld_o high to dp_res_i valid. Legal range is 1 to 15.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
start_i  in  1  request a new multiply; sampled only in IDLE.
a_i  in  9*ELEM_W  matrix A, row-major; element (r,c) at bits [ELEM_W*(3r+c) +: ELEM_W].
b_i  in  9*ELEM_W  matrix B, same packing as a_i.
dp_row_o  out  3*ELEM_W  A row r; element k at [ELEM_W*k +: ELEM_W].
dp_col_o  out  3*ELEM_W  B column c; element k at [ELEM_W*k +: ELEM_W].
dp_vld_o  out  1  one-cycle strobe: operands newly issued.
dp_res_i  in  ELEM_W  dot-product result, valid DP_LAT cycles after dp_vld_o.
busy_o  out  1  high from the cycle after start is accepted until return to IDLE.
done_o  out  1  one-cycle pulse; c_o updated in the same cycle.
c_o  out  9*ELEM_W  last completed product, row-major.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: dp_row_o, dp_col_o, dp_vld_o, busy_o, done_o, c_o.
  - Internal snapshot, result bank, element index and wait counter are cleared.
  - Reset asserted mid-run abandons the run: no done_o, c_o=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start_i=1 at an edge: snapshot a_i and b_i, set idx=0, busy_o=1, go to ISSUE.
  - start_i=0: stay in IDLE.
- ISSUE (1 cycle), at the edge:
  - dp_row_o <= A row idx/3; dp_col_o <= B column idx%3.
  - dp_vld_o <= 1; wcnt <= DP_LAT; go to WAIT.
- WAIT:
  - dp_vld_o returns to 0 after one cycle. dp_row_o and dp_col_o hold until the next ISSUE.
  - wcnt decrements each cycle.
  - When wcnt==1: capture dp_res_i into bank[idx]. If idx==8 go to DONE; otherwise idx++ and go to ISSUE.
- DONE (1 cycle): c_o <= bank, done_o=1, busy_o=0 at exit, go to IDLE.
- Latency: start accepted in cycle 0 gives done_o high in cycle 1 + 9*(DP_LAT+1). With DP_LAT=1 that is cycle 19.
- start_i while busy is ignored and not queued. start_i in the DONE cycle is also ignored. Earliest restart is the cycle after done_o.
- a_i and b_i changes after acceptance have no effect on the current run.
- c_o holds its previous value for the whole run. It never shows partial results.
- Arithmetic is done by the external unit; this block does no arithmetic.
- The bench dot model truncates to ELEM_W bits, i.e. computes modulo 2^ELEM_W.
- Index counter range is 0 to 8. It never wraps past 8; DONE resets it.

Decomposition:
- Shared package mm_pkg holds:
  - ELEM_W default and N=3.
  - State enum (IDLE/ISSUE/WAIT/DONE).
  - Functions elem(mat,r,c), row(mat,r), col(mat,c) for the packing above.
- One natural sub-module, mm3_operand_mux: combinational selection of a row and a column from the snapshots given idx. The FSM, counters and result bank stay in the top.
- The dot-product unit (mm3_dot3: three multiplies plus adder tree, truncated) stays outside this block. The bench instantiates it, delayed by DP_LAT.

Test Plan:
1. A=identity, B elements 1..9, start at cycle 0, DP_LAT=1 -> done_o only in cycle 19; c_o = 1..9; busy_o high cycles 1-18.
2. A all 2, B all 3 -> every c_o element 18 (0x0012); dp_vld_o exactly 9 one-cycle pulses, at cycles 1,3,...,17.
3. A row0 = 0x8000 x3, B col0 all 2, rest 0 -> c(0,0)=0x0000 (wrap modulo 2^16); all other elements 0.
4. Second start_i pulses at cycles 5 and 19 during run 1 -> ignored; exactly one done_o; a_i changed at cycle 3 does not alter the result.
5. rst_n low at cycle 10 mid-run, previous c_o nonzero -> all outputs 0 immediately; no done_o; a new start afterwards produces a correct product.
6. DP_LAT=3, case 2 operands -> done_o in cycle 37; dp_res_i sampled exactly 3 cycles after each dp_vld_o; c_o all 18.
